// File: rtl/vga_scanout.sv
// VGA scan-out: timing counters, framebuffer byte fetch and RGB222 colour expansion.
// Optional colour-bar test pattern is compiled in with `define VGA_TESTPAT_EN.
module vga_scanout #(
    parameter int VGA_BITS   = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [31:0]         fb_base,
    input  logic                test_mode,
    output logic [29:0]         mem_addr,
    input  logic [31:0]         mem_rdata,
    output logic                hsync,
    output logic                vsync,
    output logic                da,
    output logic [VGA_BITS-1:0] r,
    output logic [VGA_BITS-1:0] g,
    output logic [VGA_BITS-1:0] b,
    output logic                frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_W    = H_ACTIVE >> SCALE_LOG2;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic [VGA_BITS-1:0] expand(input logic [1:0] c);
        expand = {(VGA_BITS / 2){c}};
    endfunction

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] v_next;
    logic [31:0]   row_base;
    logic [31:0]   byte_addr;
    logic          h_wrap, v_wrap, row_step;
    logic          hsync_raw, vsync_raw, da_raw;
    logic [1:0]    lane_p0;
    logic          hsync_p0, vsync_p0, da_p0;
    logic [7:0]    pix_sel;

`ifdef VGA_TESTPAT_EN
    logic [2:0]    bar_p0;
`else
    logic          unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    always_comb begin
        h_wrap    = (hcnt == H_LAST);
        v_wrap    = (vcnt == V_LAST);
        v_next    = vcnt + 1'b1;
        // A new framebuffer row starts only on the first line of each replicated group.
        row_step  = (((v_next >> SCALE_LOG2) << SCALE_LOG2) == v_next) && (v_next < V_ACT);
        byte_addr = row_base + 32'(hcnt >> SCALE_LOG2);
        hsync_raw = !((hcnt >= HS_BEG) && (hcnt < HS_END));
        vsync_raw = !((vcnt >= VS_BEG) && (vcnt < VS_END));
        da_raw    = (hcnt < H_ACT) && (vcnt < V_ACT);
    end

    always_comb begin
        pix_sel = mem_rdata[8*lane_p0 +: 8];
`ifdef VGA_TESTPAT_EN
        if (test_mode)
            pix_sel = {2'b00, {2{bar_p0[2]}}, {2{bar_p0[1]}}, {2{bar_p0[0]}}};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            row_base    <= '0;
            mem_addr    <= '0;
            lane_p0     <= '0;
            hsync_p0    <= 1'b1;
            vsync_p0    <= 1'b1;
            da_p0       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            da          <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
`ifdef VGA_TESTPAT_EN
            bar_p0      <= '0;
`endif
        end else begin
            frame_start <= en && h_wrap && v_wrap;
            if (en) begin
                // Stage 0: issue word address, remember byte lane and raw timing
                mem_addr <= byte_addr[31:2];
                lane_p0  <= byte_addr[1:0];
                hsync_p0 <= hsync_raw;
                vsync_p0 <= vsync_raw;
                da_p0    <= da_raw;
`ifdef VGA_TESTPAT_EN
                bar_p0   <= 3'(hcnt >> 3);
`endif
                // Output stage: read data is valid now; blank outside the active area
                hsync <= hsync_p0;
                vsync <= vsync_p0;
                da    <= da_p0;
                r     <= da_p0 ? expand(pix_sel[5:4]) : '0;
                g     <= da_p0 ? expand(pix_sel[3:2]) : '0;
                b     <= da_p0 ? expand(pix_sel[1:0]) : '0;

                if (h_wrap) begin
                    hcnt <= '0;
                    if (v_wrap) begin
                        vcnt     <= '0;
                        row_base <= fb_base;
                    end else begin
                        vcnt <= v_next;
                        if (row_step)
                            row_base <= row_base + 32'(FB_W);
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (no scaling and 2x scaling) on an 8x4 mode,
// checked every clock against a frame-arithmetic model plus literal spot checks.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] fb_base = 32'h200;
    logic        test_mode = 1'b0;
    bit          force_ones = 1'b0;
    logic [31:0] seed;

    logic [29:0] addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic        hs0, vs0, da0, fs0, hs1, vs1, da1, fs1;
    logic [3:0]  r0, g0, b0, r1, g1, b1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [29:0] wa, input bit ones, input logic [31:0] sd);
        if (ones) return 32'hFFFF_FFFF;
        if (wa == 30'h80) return 32'h300C_033F;
        return ({2'b00, wa} * 32'h9E37_79B1) ^ sd;
    endfunction

    assign rdata0 = memf(addr0, force_ones, seed);
    assign rdata1 = memf(addr1, force_ones, seed);

    vga_scanout #(.VGA_BITS(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SCALE_LOG2(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .fb_base(fb_base), .test_mode(test_mode),
        .mem_addr(addr0), .mem_rdata(rdata0), .hsync(hs0), .vsync(vs0), .da(da0),
        .r(r0), .g(g0), .b(b0), .frame_start(fs0));

    vga_scanout #(.VGA_BITS(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SCALE_LOG2(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .fb_base(fb_base), .test_mode(test_mode),
        .mem_addr(addr1), .mem_rdata(rdata1), .hsync(hs1), .vsync(vs1), .da(da1),
        .r(r1), .g(g1), .b(b1), .frame_start(fs1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [11:0] colour(input logic [7:0] px);
        return {px[5:4], px[5:4], px[3:2], px[3:2], px[1:0], px[1:0]};
    endfunction

    function automatic logic [31:0] row_addr(input int s, input int v, input logic [31:0] base);
        int vv;
        vv = (v < 4) ? v : 3;
        return base + 32'((vv >> s) * (8 >> s));
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a, input bit ones, input logic [31:0] sd);
        logic [31:0] w;
        w = memf(a[31:2], ones, sd);
        return w[8*a[1:0] +: 8];
    endfunction

    int          mh = 0, mv = 0, tick_cnt = 0;
    logic [31:0] mbase = 0;
    logic        e_hs = 1, e_vs = 1, e_da = 0, e_fs = 0;
    logic        p_hs = 1, p_vs = 1, p_da = 0;
    logic [29:0] e_addr [2];
    logic [11:0] e_rgb  [2];
    logic [31:0] p_a    [2];

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mh = 0; mv = 0; mbase = 0; tick_cnt = 0;
            e_hs = 1; e_vs = 1; e_da = 0; e_fs = 0;
            p_hs = 1; p_vs = 1; p_da = 0;
            for (int i = 0; i < 2; i++) begin
                e_addr[i] = 0; e_rgb[i] = 0; p_a[i] = 0;
            end
        end else if (en) begin
            tick_cnt++;
            e_hs = p_hs; e_vs = p_vs; e_da = p_da;
            for (int i = 0; i < 2; i++)
                e_rgb[i] = p_da ? colour(byte_at(p_a[i], force_ones, seed)) : 12'h000;
            p_hs = !(mh >= 10 && mh < 12);
            p_vs = (mv != 5);
            p_da = (mh < 8) && (mv < 4);
            for (int i = 0; i < 2; i++) begin
                p_a[i]    = row_addr(i, mv, mbase) + 32'(mh >> i);
                e_addr[i] = p_a[i][31:2];
            end
            e_fs = (mh == 13) && (mv == 6);
            mh = mh + 1;
            if (mh == 14) begin
                mh = 0;
                mv = mv + 1;
                if (mv == 7) begin
                    mv = 0;
                    mbase = fb_base;
                end
            end
        end else begin
            e_fs = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("hsync0", 32'(hs0), 32'(e_hs));
            chk("vsync0", 32'(vs0), 32'(e_vs));
            chk("da0",    32'(da0), 32'(e_da));
            chk("fs0",    32'(fs0), 32'(e_fs));
            chk("rgb0",   32'({r0, g0, b0}), 32'(e_rgb[0]));
            chk("addr0",  32'(addr0), 32'(e_addr[0]));
            chk("hsync1", 32'(hs1), 32'(e_hs));
            chk("vsync1", 32'(vs1), 32'(e_vs));
            chk("da1",    32'(da1), 32'(e_da));
            chk("fs1",    32'(fs1), 32'(e_fs));
            chk("rgb1",   32'({r1, g1, b1}), 32'(e_rgb[1]));
            chk("addr1",  32'(addr1), 32'(e_addr[1]));
        end
    end

    // ---------------- stimulus ----------------
    initial forever begin
        @(negedge clk);
        en = en ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic en_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!en) @(posedge clk);
        end
        #1;
    endtask

    task automatic wait_fs(output int ticks_at);
        ticks_at = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (fs0) begin
                ticks_at = tick_cnt;
                break;
            end
        end
        if (ticks_at < 0) begin
            checks++;
            errors++;
            $display("FAIL fs_timeout: no frame_start within 600 clocks");
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hsync"}, 32'(hs0), 32'd1);
        chk({tag, "_vsync"}, 32'(vs0), 32'd1);
        chk({tag, "_da"},    32'(da0), 32'd0);
        chk({tag, "_rgb"},   32'({r0, g0, b0, r1, g1, b1}), 32'd0);
        chk({tag, "_addr"},  32'(addr0) | 32'(addr1), 32'd0);
        chk({tag, "_fs"},    32'(fs0), 32'd0);
    endtask

    initial begin
        int t1, t2, cnt0, cnt1, guard;
        seed = $urandom;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        started = 1'b1;

        wait_fs(t1);
        chk("first_fs_ticks", 32'(t1), 32'd98);

        en_ticks(1);
        chk("lane_addr0", 32'(addr0), 32'h80);
        chk("lane_addr1", 32'(addr1), 32'h80);
        en_ticks(1);
        chk("lane_px0_s0", 32'({r0, g0, b0}), 32'hFFF);
        chk("lane_px0_s1", 32'({r1, g1, b1}), 32'hFFF);
        en_ticks(1);
        chk("lane_px1_s0", 32'({r0, g0, b0}), 32'h00F);
        chk("lane_px1_s1", 32'({r1, g1, b1}), 32'hFFF);
        en_ticks(1);
        chk("lane_px2_s0", 32'({r0, g0, b0}), 32'h0F0);
        chk("lane_px2_s1", 32'({r1, g1, b1}), 32'h00F);
        en_ticks(1);
        chk("lane_px3_s0", 32'({r0, g0, b0}), 32'hF00);
        chk("lane_px3_s1", 32'({r1, g1, b1}), 32'h00F);

        en_ticks(10);
        chk("line1_addr1", 32'(addr1), 32'h80);
        fb_base = 32'h400;
        en_ticks(14);
        chk("line2_addr1", 32'(addr1), 32'h81);
        chk("line2_addr0", 32'(addr0), 32'h84);

        wait_fs(t2);
        chk("fs_period", 32'(t2 - t1), 32'd98);
        en_ticks(1);
        chk("newbase_addr0", 32'(addr0), 32'h100);
        chk("newbase_addr1", 32'(addr1), 32'h100);

        force_ones = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        repeat (98) begin
            en_ticks(1);
            if ({r0, g0, b0} == 12'hFFF) cnt0++;
            if ({r1, g1, b1} == 12'hFFF) cnt1++;
        end
        chk("blank_full0", 32'(cnt0), 32'd32);
        chk("blank_full1", 32'(cnt1), 32'd32);
        force_ones = 1'b0;

        repeat (400) begin
            en_ticks(1);
            if ($urandom_range(0, 29) == 0) fb_base = $urandom_range(0, 65535);
        end
        fb_base = 32'h200;

        guard = 0;
        en_ticks(1);
        while (mh != 5 && guard < 20) begin
            en_ticks(1);
            guard++;
        end
        #1;
        reset = 1'b1;
        #1;
        chk_reset_state("async");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_fs(t1);
        chk("reset_fs_ticks", 32'(t1), 32'd98);
        en_ticks(1);
        chk("restart_addr0", 32'(addr0), 32'h80);
        en_ticks(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
